// File: rtl/piece_move_sequencer_if.sv
// Candidate-move handshake between the piece move sequencer and the
// collision checker. The sequencer (master) offers one candidate at a
// time. It holds chk_req and the candidate fields until the checker
// (slave) answers with chk_ack, qualified by chk_ok.
interface piece_move_sequencer_if;
  logic       chk_req;
  logic [3:0] chk_x;
  logic [4:0] chk_y;
  logic [1:0] chk_rot;
  logic       chk_ack;
  logic       chk_ok;

  modport master (
    output chk_req, chk_x, chk_y, chk_rot,
    input  chk_ack, chk_ok
  );

  modport slave (
    input  chk_req, chk_x, chk_y, chk_rot,
    output chk_ack, chk_ok
  );
endinterface

// File: rtl/piece_move_sequencer.sv
// piece_move_sequencer: owns the falling piece position and rotation.
// Keyboard requests and gravity steps are merged into one candidate at a
// time. Each candidate is offered to the collision checker and committed
// only on approval. A blocked downward step locks the piece, and the next
// piece respawns at SPAWN_X.
// Optional feature: define SOFT_DROP_EN to make keycode 0x16 a soft-drop
// key. Without it, only gravity moves the piece down.
module piece_move_sequencer #(
  parameter int GRAV_TICKS = 30,
  parameter int BOARD_W    = 10,
  parameter int BOARD_H    = 20,
  parameter int SPAWN_X    = 4
) (
  input  logic                          Clk,
  input  logic                          Reset,
  input  logic [7:0]                    keycode,
  input  logic                          frame_tick,
  piece_move_sequencer_if.master        chk,
  output logic [3:0]                    piece_x,
  output logic [4:0]                    piece_y,
  output logic [1:0]                    rotation,
  output logic                          moved,
  output logic                          lock
);

  localparam int                CNT_W    = (GRAV_TICKS > 1) ? $clog2(GRAV_TICKS) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(GRAV_TICKS - 1);
  localparam logic [3:0]        X_MAX    = 4'(BOARD_W - 1);
  localparam logic [4:0]        Y_MAX    = 5'(BOARD_H - 1);
  localparam logic [3:0]        X_SPAWN  = 4'(SPAWN_X);

  localparam logic [7:0] KEY_NONE  = 8'h00;
  localparam logic [7:0] KEY_LEFT  = 8'h04;
  localparam logic [7:0] KEY_RIGHT = 8'h07;
  localparam logic [7:0] KEY_ROT   = 8'h1A;
`ifdef SOFT_DROP_EN
  localparam logic [7:0] KEY_DOWN  = 8'h16;
`endif

  // Compact encoding of a latched key request
  localparam logic [1:0] K_LEFT  = 2'd0;
  localparam logic [1:0] K_RIGHT = 2'd1;
  localparam logic [1:0] K_DOWN  = 2'd2;
  localparam logic [1:0] K_ROT   = 2'd3;

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_REQ  = 2'b01;
  localparam logic [1:0] S_LOCK = 2'b10;

  logic [7:0]       keycode_r;
  logic             armed_r;
  logic             key_pend_r;
  logic [1:0]       key_code_r;
  logic [CNT_W-1:0] grav_cnt_r;
  logic             grav_pend_r;
  logic [1:0]       state_r;
  logic             chk_req_r;
  logic [3:0]       cand_x_r;
  logic [4:0]       cand_y_r;
  logic [1:0]       cand_rot_r;
  logic             cand_is_key_r;
  logic             cand_is_down_r;
  logic [3:0]       piece_x_r;
  logic [4:0]       piece_y_r;
  logic [1:0]       rot_r;
  logic             moved_r;
  logic             lock_r;

  logic             key_recog_s;
  logic [1:0]       key_enc_s;
  logic             tick_wrap_s;
  logic [1:0]       next_state_s;
  logic             load_cand_s;
  logic [3:0]       nxt_x_s;
  logic [4:0]       nxt_y_s;
  logic [1:0]       nxt_rot_s;
  logic             nxt_is_key_s;
  logic             nxt_is_down_s;
  logic             key_illegal_s;
  logic             commit_s;
  logic             clr_key_s;
  logic             clr_grav_s;
  logic             do_lock_s;
  logic             restart_cnt_s;

  // Classify the registered keycode into a recognised move request
  always_comb begin
    key_recog_s = 1'b0;
    key_enc_s   = K_LEFT;
    case (keycode_r)
      KEY_LEFT:  begin key_recog_s = 1'b1; key_enc_s = K_LEFT;  end
      KEY_RIGHT: begin key_recog_s = 1'b1; key_enc_s = K_RIGHT; end
      KEY_ROT:   begin key_recog_s = 1'b1; key_enc_s = K_ROT;   end
`ifdef SOFT_DROP_EN
      KEY_DOWN:  begin key_recog_s = 1'b1; key_enc_s = K_DOWN;  end
`endif
      default:   begin key_recog_s = 1'b0; key_enc_s = K_LEFT;  end
    endcase
  end

  assign tick_wrap_s = frame_tick && (grav_cnt_r == CNT_LAST);

  // Sequencer decisions: candidate formation, checker response, lock
  always_comb begin
    next_state_s  = state_r;
    load_cand_s   = 1'b0;
    nxt_x_s       = piece_x_r;
    nxt_y_s       = piece_y_r;
    nxt_rot_s     = rot_r;
    nxt_is_key_s  = 1'b0;
    nxt_is_down_s = 1'b0;
    key_illegal_s = 1'b0;
    commit_s      = 1'b0;
    clr_key_s     = 1'b0;
    clr_grav_s    = 1'b0;
    do_lock_s     = 1'b0;
    restart_cnt_s = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (key_pend_r) begin
          case (key_code_r)
            K_LEFT:  begin key_illegal_s = (piece_x_r == 4'd0);  nxt_x_s = piece_x_r - 4'd1; end
            K_RIGHT: begin key_illegal_s = (piece_x_r == X_MAX); nxt_x_s = piece_x_r + 4'd1; end
            K_DOWN:  begin key_illegal_s = (piece_y_r == Y_MAX); nxt_y_s = piece_y_r + 5'd1; end
            K_ROT:   begin key_illegal_s = 1'b0;                 nxt_rot_s = rot_r + 2'd1;   end
            default: begin key_illegal_s = 1'b1; end
          endcase
          if (key_illegal_s) begin
            // Move that obviously leaves the board: drop it without asking
            clr_key_s    = 1'b1;
            next_state_s = S_IDLE;
          end else begin
            load_cand_s   = 1'b1;
            nxt_is_key_s  = 1'b1;
            nxt_is_down_s = (key_code_r == K_DOWN);
            next_state_s  = S_REQ;
          end
        end else if (grav_pend_r) begin
          if (piece_y_r == Y_MAX) begin
            // Already on the floor row: the step is blocked by definition
            next_state_s = S_LOCK;
          end else begin
            load_cand_s   = 1'b1;
            nxt_y_s       = piece_y_r + 5'd1;
            nxt_is_down_s = 1'b1;
            next_state_s  = S_REQ;
          end
        end else begin
          next_state_s = S_IDLE;
        end
      end
      S_REQ: begin
        if (chk.chk_ack) begin
          if (chk.chk_ok) begin
            commit_s = 1'b1;
            if (cand_is_key_r) begin
              clr_key_s = 1'b1;
`ifdef SOFT_DROP_EN
              restart_cnt_s = cand_is_down_r;
`endif
            end else begin
              clr_grav_s = 1'b1;
            end
            next_state_s = S_IDLE;
          end else if (cand_is_down_r) begin
            // Blocked downward step: the piece has landed
            if (cand_is_key_r) begin
              clr_key_s = 1'b1;
            end else begin
              clr_grav_s = 1'b1;
            end
            next_state_s = S_LOCK;
          end else begin
            clr_key_s    = 1'b1;
            next_state_s = S_IDLE;
          end
        end else begin
          next_state_s = S_REQ;
        end
      end
      S_LOCK: begin
        do_lock_s    = 1'b1;
        next_state_s = S_IDLE;
      end
      default: begin
        next_state_s = S_IDLE;
      end
    endcase
  end

  // Key capture: one request per press, re-armed only by key release
  always_ff @(posedge Clk) begin
    if (Reset) begin
      keycode_r  <= 8'h00;
      armed_r    <= 1'b1;
      key_pend_r <= 1'b0;
      key_code_r <= K_LEFT;
    end else begin
      keycode_r <= keycode;
      if (keycode_r == KEY_NONE) begin
        armed_r <= 1'b1;
      end else if (armed_r && key_recog_s) begin
        armed_r <= 1'b0;
      end else begin
        armed_r <= armed_r;
      end
      if (do_lock_s || clr_key_s) begin
        key_pend_r <= 1'b0;
      end else if (armed_r && key_recog_s && !key_pend_r) begin
        key_pend_r <= 1'b1;
        key_code_r <= key_enc_s;
      end else begin
        key_pend_r <= key_pend_r;
      end
    end
  end

  // Gravity timer: one pending step per GRAV_TICKS frames, never queued deeper
  always_ff @(posedge Clk) begin
    if (Reset) begin
      grav_cnt_r  <= '0;
      grav_pend_r <= 1'b0;
    end else if (do_lock_s) begin
      grav_cnt_r  <= '0;
      grav_pend_r <= 1'b0;
    end else begin
      if (restart_cnt_s) begin
        grav_cnt_r <= '0;
      end else if (tick_wrap_s) begin
        grav_cnt_r <= '0;
      end else if (frame_tick) begin
        grav_cnt_r <= grav_cnt_r + CNT_W'(1);
      end else begin
        grav_cnt_r <= grav_cnt_r;
      end
      // A fresh gravity step outranks clearing the one just serviced
      if (tick_wrap_s && !restart_cnt_s) begin
        grav_pend_r <= 1'b1;
      end else if (clr_grav_s) begin
        grav_pend_r <= 1'b0;
      end else begin
        grav_pend_r <= grav_pend_r;
      end
    end
  end

  // State, request strobe and the candidate held stable for the checker
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_r        <= S_IDLE;
      chk_req_r      <= 1'b0;
      cand_x_r       <= 4'd0;
      cand_y_r       <= 5'd0;
      cand_rot_r     <= 2'd0;
      cand_is_key_r  <= 1'b0;
      cand_is_down_r <= 1'b0;
    end else begin
      state_r   <= next_state_s;
      chk_req_r <= (next_state_s == S_REQ);
      if (load_cand_s) begin
        cand_x_r       <= nxt_x_s;
        cand_y_r       <= nxt_y_s;
        cand_rot_r     <= nxt_rot_s;
        cand_is_key_r  <= nxt_is_key_s;
        cand_is_down_r <= nxt_is_down_s;
      end else begin
        cand_x_r <= cand_x_r;
      end
    end
  end

  // Authoritative piece registers plus the moved/lock pulses
  always_ff @(posedge Clk) begin
    if (Reset) begin
      piece_x_r <= X_SPAWN;
      piece_y_r <= 5'd0;
      rot_r     <= 2'd0;
      moved_r   <= 1'b0;
      lock_r    <= 1'b0;
    end else begin
      moved_r <= commit_s;
      lock_r  <= (next_state_s == S_LOCK);
      if (do_lock_s) begin
        piece_x_r <= X_SPAWN;
        piece_y_r <= 5'd0;
        rot_r     <= 2'd0;
      end else if (commit_s) begin
        piece_x_r <= cand_x_r;
        piece_y_r <= cand_y_r;
        rot_r     <= cand_rot_r;
      end else begin
        piece_x_r <= piece_x_r;
      end
    end
  end

  assign chk.chk_req = chk_req_r;
  assign chk.chk_x   = cand_x_r;
  assign chk.chk_y   = cand_y_r;
  assign chk.chk_rot = cand_rot_r;
  assign piece_x     = piece_x_r;
  assign piece_y     = piece_y_r;
  assign rotation    = rot_r;
  assign moved       = moved_r;
  assign lock        = lock_r;

endmodule
